// File: rtl/poly_mau_sched.sv
// Burst sequencer for one POLY_MAU: issues buffered operand pairs, captures in-order results,
// and drives a scope trigger that spans exactly the active MAU window.
module poly_mau_sched #(
    parameter int DW    = 24,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int TMO   = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_a,
    input  logic [DW-1:0] wr_b,
    input  logic          start,
    input  logic [AW:0]   num,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          trig,
    output logic          mau_enable,
    output logic [DW-1:0] mau_a,
    output logic [DW-1:0] mau_b,
    input  logic          mau_valid,
    input  logic [DW-1:0] mau_o0,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t        state_r, state_s;
    logic [AW:0]   n_r, n_s;
    logic [AW:0]   issue_idx_r, issue_s;
    logic [AW:0]   rcv_idx_r, rcv_s, rcv_next_s;
    logic [CW-1:0] idle_cnt_r, cnt_s, cnt_inc_s;
    logic          busy_r, done_r, err_r, err_s, trig_r;
    logic          mau_enable_r, en_s;
    logic [DW-1:0] mau_a_r, mau_b_r, a_s, b_s;

    logic [DW-1:0] op_a_r [DEPTH];
    logic [DW-1:0] op_b_r [DEPTH];
    logic [DW-1:0] res_r  [DEPTH];

    logic          wr_ok_s, valid_ok_s, spurious_s, bypass_s;
    logic [AW:0]   num_clip_s;
    logic [AW-1:0] fetch_idx_s;
    logic [DW-1:0] op_a_s, op_b_s;

    // A valid is only accepted while a result is actually outstanding.
    assign wr_ok_s     = wr_en && (state_r == IDLE);
    assign valid_ok_s  = mau_valid && (state_r != IDLE) && (rcv_idx_r != issue_idx_r);
    assign spurious_s  = mau_valid && !valid_ok_s;
    assign rcv_next_s  = valid_ok_s ? (rcv_idx_r + (AW+1)'(1)) : rcv_idx_r;
    assign cnt_inc_s   = idle_cnt_r + CW'(1);
    assign num_clip_s  = (num > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num;
    // The first pair is fetched in IDLE, so a same-cycle write must bypass the buffer.
    assign fetch_idx_s = (state_r == IDLE) ? '0 : issue_idx_r[AW-1:0];
    assign bypass_s    = wr_ok_s && (wr_addr == fetch_idx_s);
    assign op_a_s      = bypass_s ? wr_a : op_a_r[fetch_idx_s];
    assign op_b_s      = bypass_s ? wr_b : op_b_r[fetch_idx_s];

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_s = state_r;
        n_s     = n_r;
        issue_s = issue_idx_r;
        rcv_s   = rcv_next_s;
        cnt_s   = valid_ok_s ? '0 : idle_cnt_r;
        err_s   = err_r | spurious_s;
        en_s    = 1'b0;
        a_s     = '0;
        b_s     = '0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    n_s     = num_clip_s;
                    rcv_s   = '0;
                    cnt_s   = '0;
                    err_s   = spurious_s;
                    if (num_clip_s == '0) begin
                        issue_s = '0;
                        state_s = FIN;
                    end else begin
                        issue_s = (AW+1)'(1);
                        en_s    = 1'b1;
                        a_s     = op_a_s;
                        b_s     = op_b_s;
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (issue_idx_r < n_r) begin
                    issue_s = issue_idx_r + (AW+1)'(1);
                    en_s    = 1'b1;
                    a_s     = op_a_s;
                    b_s     = op_b_s;
                end else if (rcv_next_s == n_r) begin
                    state_s = FIN;
                end else begin
                    state_s = DRAIN;
                end
            end
            DRAIN: begin
                if (rcv_next_s == n_r) begin
                    state_s = FIN;
                end else if (!valid_ok_s && (cnt_inc_s == CW'(TMO))) begin
                    err_s   = 1'b1;
                    state_s = FIN;
                end else if (!valid_ok_s) begin
                    cnt_s = cnt_inc_s;
                end else begin
                    cnt_s = '0;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; trig follows the ISSUE/DRAIN window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            n_r          <= '0;
            issue_idx_r  <= '0;
            rcv_idx_r    <= '0;
            idle_cnt_r   <= '0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            trig_r       <= 1'b0;
            mau_enable_r <= 1'b0;
            mau_a_r      <= '0;
            mau_b_r      <= '0;
        end else begin
            state_r      <= state_s;
            n_r          <= n_s;
            issue_idx_r  <= issue_s;
            rcv_idx_r    <= rcv_s;
            idle_cnt_r   <= cnt_s;
            busy_r       <= (state_s != IDLE);
            done_r       <= (state_r == FIN);
            err_r        <= err_s;
            trig_r       <= (state_s == ISSUE) || (state_s == DRAIN);
            mau_enable_r <= en_s;
            mau_a_r      <= a_s;
            mau_b_r      <= b_s;
        end
    end

    // Operand buffer: writable only while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                op_a_r[i] <= '0;
                op_b_r[i] <= '0;
            end
        end else if (wr_ok_s) begin
            op_a_r[wr_addr] <= wr_a;
            op_b_r[wr_addr] <= wr_b;
        end
    end

    // Result buffer: written in arrival order, untouched entries persist.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                res_r[i] <= '0;
            end
        end else if (valid_ok_s) begin
            res_r[rcv_idx_r[AW-1:0]] <= mau_o0;
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;
    assign trig       = trig_r;
    assign mau_enable = mau_enable_r;
    assign mau_a      = mau_a_r;
    assign mau_b      = mau_b_r;
    assign rd_data    = res_r[rd_addr];

endmodule

// File: doc/poly_mau_sched.md
Name: poly_mau_sched

Overview:
- Sequencer that feeds a burst of coefficient pairs into one POLY_MAU instance and collects its results in order.
- Replaces the free-running enable-window counter used today. The local-bus interface loads an operand buffer, issues start, then reads back the results.
- Drives the oscilloscope trigger so it covers exactly the active MAU window, which keeps side-channel traces aligned.

Parameters:
- DW, 24, operand/result width (matches poly_mau_a/b/o0).
- DEPTH, 8, operand-pair and result buffer entries.
- AW, 3, log2(DEPTH).
- TMO, 12, drain-timeout cycles without mau_valid before aborting.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- wr_en  in  1  operand buffer write strobe.
- wr_addr  in  AW  operand buffer write index.
- wr_a  in  DW  operand A to store.
- wr_b  in  DW  operand B to store.
- start  in  1  single-cycle request to run a burst.
- num  in  AW+1  number of pairs to process, sampled on start.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse at burst end.
- err  out  1  sticky: timeout or unexpected valid; cleared by next accepted start.
- trig  out  1  scope trigger.
- mau_enable  out  1  per-pair issue strobe to POLY_MAU.
- mau_a  out  DW  operand A to POLY_MAU.
- mau_b  out  DW  operand B to POLY_MAU.
- mau_valid  in  1  POLY_MAU result valid.
- mau_o0  in  DW  POLY_MAU result.
- rd_addr  in  AW  result buffer read index.
- rd_data  out  DW  result buffer data, combinational read.

Behaviour:
- Reset: asynchronous, active-low rst_n; clock clk, all flops on posedge.
- Reset values: every output 0, both buffers 0, FSM in IDLE, all counters 0.
- Reset asserted mid-burst aborts immediately; no done pulse is produced.
- FSM states: IDLE, ISSUE, DRAIN, FIN.
- IDLE:
  - If start is seen at cycle t, latch n = min(num, DEPTH), clear err, go to ISSUE.
  - busy = 1 from t+1.
  - If n == 0, go directly to FIN; no mau_enable is ever issued.
- ISSUE:
  - Cycles t+1 .. t+n: mau_enable = 1 with mau_a/mau_b = buffer[issue_idx]; issue_idx increments 0..n-1.
  - All issue outputs are registered.
  - mau_a/mau_b return to 0 when mau_enable is 0.
  - After the last issue, go to DRAIN. If all results have already arrived, go to FIN.
- Result capture (any state):
  - On mau_valid, write mau_o0 to result[rcv_idx] and increment rcv_idx.
  - Results are stored in arrival order; POLY_MAU is in-order, so result k pairs with operand k.
  - mau_valid while rcv_idx == issued count (nothing outstanding), or while in IDLE: set err, do not write, do not increment.
- DRAIN:
  - Idle counter resets on every mau_valid.
  - If rcv_idx == n, go to FIN.
  - If the counter reaches TMO, set err and go to FIN.
- FIN: lasts one cycle. done = 1, busy = 0 on the following edge, next state IDLE.
- trig:
  - 1 from the first mau_enable cycle through the cycle the last result is captured (or the timeout cycle).
  - Registered, glitch-free.
  - Never asserted when n == 0.
- Ignored inputs:
  - start while busy: no effect.
  - wr_en while busy: no effect; the operand buffer is locked during a burst.
  - wr_en in IDLE writes the buffer in 1 cycle.
- Same-cycle events:
  - start and wr_en in the same IDLE cycle: the write is committed, and the burst uses the new value.
  - The last issue and a mau_valid in the same cycle are both handled.
- Result buffer contents persist across bursts. Entries at index >= n keep their old values.
- Counter widths: issue_idx and rcv_idx are AW+1 bits, so n == DEPTH causes no wrap.

Test Plan:
- Load pairs (1,2),(3,4),(5,6); model MAU as a fixed 6-cycle delay returning a*b mod 8380417; start with num=3:
  - mau_enable high exactly 3 consecutive cycles from start+1.
  - Results read back 2, 12, 30.
  - done pulses once; err = 0.
- num=0 start: busy high for 1 cycle, done pulse at t+2, mau_enable and trig never high.
- num=15 with DEPTH=8: exactly 8 issues, 8 results captured, no index wrap.
- Model drops the 3rd valid: err = 1 and done fire TMO cycles after the 2nd valid. A following normal burst clears err.
- start and wr_en pulses during a burst:
  - The extra start is ignored.
  - The operand buffer is unchanged after the burst.
  - A spurious mau_valid in IDLE sets err with the result buffer untouched.
- rst_n asserted during DRAIN: all outputs 0 immediately, no done pulse. The next burst runs normally.
